alu_iter: RTL and testbench

Parametrised, sequential execute-stage ALU for the RISC-V pipeline: a generalisation of the single-cycle ALU to configurable `WIDTH`. It adds a start/ready/valid handshake, registered results and flags, and an iterative multiply/divide path that stalls the pipeline while busy. Single-cycle operations issue back-to-back every clock. Multiply and divide occupy the unit for `WIDTH` cycles.

---
 rtl/alu_iter_if.sv | 27 ++
 rtl/alu_iter.sv | 173 +++++++++++++++++
 tb/tb_alu_iter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// Execute-stage ALU bus: operands/opcode from the pipeline, registered result and flags back.
interface alu_iter_if #(parameter int WIDTH = 32);
  // Handshake: Start is accepted on a rising edge where Ready=1 and Kill=0. Ready=0 means
  // the unit is busy and Start is dropped, never queued. Valid is a one-cycle pulse per
  // completed op; results are not back-pressured and ALUResult/flags hold until the next Valid.
  logic             Start;
  logic             Kill;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             Ready;
  logic             Valid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Lt;
  logic             Ltu;

  modport master (
    output Start, Kill, SrcA, SrcB, ALUControl,
    input  Ready, Valid, ALUResult, Zero, Lt, Ltu
  );

  modport slave (
    input  Start, Kill, SrcA, SrcB, ALUControl,
    output Ready, Valid, ALUResult, Zero, Lt, Ltu
  );
endinterface

// File: rtl/alu_iter.sv
// Sequential RISC-V execute ALU: single-cycle ops plus iterative shift-add MUL and restoring DIV.
// Define ALU_ITER_DIV_EN to build the divider; otherwise DIVU/REMU are single-cycle placeholders.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_iter_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc;
  logic               sel_hi, lt_cap, ltu_cap;
  logic [WIDTH-1:0]   result;
  logic               zero, lt, ltu, valid;

  logic [CW-1:0]    shamt;
  logic             lt_now, ltu_now, is_mul, is_div, last;
  logic [WIDTH-1:0] alu_out;

  assign shamt   = bus.SrcB[CW-1:0];
  assign lt_now  = $signed(bus.SrcA) < $signed(bus.SrcB);
  assign ltu_now = bus.SrcA < bus.SrcB;
  assign is_mul  = (bus.ALUControl[3:1] == 3'b101);
`ifdef ALU_ITER_DIV_EN
  assign is_div  = (bus.ALUControl[3:1] == 3'b110);
`else
  assign is_div  = 1'b0;
`endif
  assign last    = (cnt == LAST);

  always_comb begin
    alu_out = '0;
    case (bus.ALUControl)
      4'b0000: alu_out = bus.SrcA + bus.SrcB;
      4'b0001: alu_out = bus.SrcA - bus.SrcB;
      4'b0010: alu_out = bus.SrcA & bus.SrcB;
      4'b0011: alu_out = bus.SrcA | bus.SrcB;
      4'b0111: alu_out = bus.SrcA ^ bus.SrcB;
      4'b0100: alu_out = {{(WIDTH-1){1'b0}}, lt_now};
      4'b0101: alu_out = {{(WIDTH-1){1'b0}}, ltu_now};
      4'b0110: alu_out = bus.SrcA << shamt;
      4'b1000: alu_out = bus.SrcA >> shamt;
      4'b1001: alu_out = $unsigned($signed(bus.SrcA) >>> shamt);
`ifndef ALU_ITER_DIV_EN
      4'b1100: alu_out = '1;
      4'b1101: alu_out = bus.SrcA;
`endif
      default: alu_out = '0;
    endcase
  end

  // One multiplier bit per step, LSB first: add into the high half, then shift the pair right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     mul_res;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (op_b[0] ? op_a : {WIDTH{1'b0}})};
  assign mul_next = (2*WIDTH)'({mul_sum, acc[WIDTH-1:0]} >> 1);
  assign mul_res  = sel_hi ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];

`ifdef ALU_ITER_DIV_EN
  // Restoring step: op_a shifts the dividend out MSB first and the quotient in LSB first.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next, quo_next, div_res;
  assign div_shift = {acc[WIDTH-1:0], op_a[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {op_a[WIDTH-2:0], div_ge};
  assign div_res   = sel_hi ? rem_next : quo_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.Start && !bus.Kill) begin
          if (is_mul)      state_next = MUL;
          else if (is_div) state_next = DIV;
        end
      end
      MUL, DIV: if (bus.Kill || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;  op_a <= '0;  op_b <= '0;  acc <= '0;
      sel_hi <= 1'b0;  lt_cap <= 1'b0;  ltu_cap <= 1'b0;
      result <= '0;  zero <= 1'b1;  lt <= 1'b0;  ltu <= 1'b0;  valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Kill) begin
            lt_cap  <= lt_now;
            ltu_cap <= ltu_now;
            sel_hi  <= bus.ALUControl[0];
            cnt     <= '0;
            if (is_mul || is_div) begin
              op_a <= bus.SrcA;
              op_b <= bus.SrcB;
              acc  <= '0;
            end else begin
              result <= alu_out;
              zero   <= (alu_out == '0);
              lt     <= lt_now;
              ltu    <= ltu_now;
              valid  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (bus.Kill) cnt <= '0;
          else begin
            acc  <= mul_next;
            op_b <= op_b >> 1;
            cnt  <= cnt + 1'b1;
            if (last) begin
              result <= mul_res;
              zero   <= (mul_res == '0);
              lt     <= lt_cap;
              ltu    <= ltu_cap;
              valid  <= 1'b1;
              cnt    <= '0;
            end
          end
        end
`ifdef ALU_ITER_DIV_EN
        DIV: begin
          if (bus.Kill) cnt <= '0;
          else begin
            acc  <= {{WIDTH{1'b0}}, rem_next};
            op_a <= quo_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
              result <= div_res;
              zero   <= (div_res == '0);
              lt     <= lt_cap;
              ltu    <= ltu_cap;
              valid  <= 1'b1;
              cnt    <= '0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.Ready     = (state == IDLE);
  assign bus.Valid     = valid;
  assign bus.ALUResult = result;
  assign bus.Zero      = zero;
  assign bus.Lt        = lt;
  assign bus.Ltu       = ltu;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed plan steps then random ops checked against an arithmetic model.
module tb_alu_iter;
  localparam int W = 32;
`ifdef ALU_ITER_DIV_EN
  localparam bit DIV_EN = 1'b1;
  localparam logic [3:0] KILL_OP = 4'b1100;
`else
  localparam bit DIV_EN = 1'b0;
  localparam logic [3:0] KILL_OP = 4'b1010;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  alu_iter_if #(.WIDTH(W)) bus();

  alu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0]    p;
    logic signed [W-1:0] s;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    s = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd7:  return a ^ b;
      4'd4:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd5:  return (a < b) ? 1 : 0;
      4'd6:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return s >>> b[4:0];
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (b == 0 || !DIV_EN) ? '1 : a / b;
      4'd13: return (b == 0 || !DIV_EN) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11) || (DIV_EN && (op == 4'd12 || op == 4'd13));
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input string tag);
    int lat, rlow, exp_lat;
    logic [W-1:0] exp_r;
    exp_r = ref_result(op, a, b);
    exp_q.push_back(exp_r);
    exp_lat = is_iter(op) ? W + 1 : 1;
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 1; rlow = 0;
    while (!bus.Valid && lat < 100) begin
      if (!bus.Ready) rlow++;
      bus.Start = poke && (lat == 5);
      if (bus.Start) begin bus.ALUControl = 4'd0; bus.SrcA = 1; bus.SrcB = 1; end
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_ready_low"}, W'(rlow), W'(exp_lat - 1));
    check({tag, "_ready_at_valid"}, W'(bus.Ready), W'(1));
    check({tag, "_result"}, bus.ALUResult, exp_q.pop_front());
    check({tag, "_zero"}, W'(bus.Zero), W'(exp_r == 0));
    check({tag, "_lt"}, W'(bus.Lt), W'($signed(a) < $signed(b)));
    check({tag, "_ltu"}, W'(bus.Ltu), W'(a < b));
    last_res = exp_r;
    @(negedge clk);
    check({tag, "_valid_drop"}, W'(bus.Valid), W'(0));
  endtask

  logic [3:0]   bb_op[4] = '{4'd1, 4'd9, 4'd4, 4'd5};
  logic [W-1:0] bb_a[4]  = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] bb_b[4]  = '{32'd3, 32'd4, 32'd1, 32'd1};

  initial begin
    int vcount;
    logic [W-1:0] e, ra, rb;
    logic [3:0] rop;

    // Reset held with Start asserted
    bus.Start = 1'b1; bus.Kill = 1'b0; bus.ALUControl = 4'd0; bus.SrcA = 5; bus.SrcB = 7;
    repeat (3) @(negedge clk);
    check("rst_ready", W'(bus.Ready), W'(1));
    check("rst_valid", W'(bus.Valid), W'(0));
    check("rst_result", bus.ALUResult, '0);
    check("rst_zero", W'(bus.Zero), W'(1));
    check("rst_lt", W'(bus.Lt), W'(0));
    check("rst_ltu", W'(bus.Ltu), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    check("first_add_valid", W'(bus.Valid), W'(1));
    check("first_add_result", bus.ALUResult, ref_result(4'd0, 5, 7));
    check("first_add_zero", W'(bus.Zero), W'(0));
    @(negedge clk);
    check("first_add_pulse", W'(bus.Valid), W'(0));

    // Back-to-back single-cycle ops
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        check("b2b_valid", W'(bus.Valid), W'(1));
        check("b2b_result", bus.ALUResult, e);
        check("b2b_zero", W'(bus.Zero), W'(e == 0));
        last_res = e;
      end
      if (i < 4) begin
        bus.Start = 1'b1; bus.ALUControl = bb_op[i]; bus.SrcA = bb_a[i]; bus.SrcB = bb_b[i];
        exp_q.push_back(ref_result(bb_op[i], bb_a[i], bb_b[i]));
      end else bus.Start = 1'b0;
    end

    // Iterative ops from the plan, MUL with a Start pulsed while busy
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_ff");
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulhu_ff");
    run_op(4'd12, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(4'd13, 32'd100, 32'd7, 1'b0, "remu_100_7");
    run_op(4'd12, 32'd12345, 32'd0, 1'b0, "divu_by0");
    run_op(4'd13, 32'd9, 32'd0, 1'b0, "remu_by0");

    // Kill at iteration 10 of an iterative op
    run_op(4'd0, 32'h1234, 32'h1, 1'b0, "pre_kill_add");
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = KILL_OP; bus.SrcA = 100; bus.SrcB = 7;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    bus.Kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Kill = 1'b0;
    check("kill_valid", W'(bus.Valid), W'(0));
    check("kill_ready", W'(bus.Ready), W'(1));
    check("kill_result", bus.ALUResult, last_res);
    check("kill_zero", W'(bus.Zero), W'(last_res == 0));
    check("kill_state", W'(dbg_state), W'(0));
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Valid) vcount++;
    end
    check("kill_no_late_valid", W'(vcount), W'(0));

    // Kill in IDLE suppresses a same-cycle Start
    bus.Start = 1'b1; bus.Kill = 1'b1; bus.ALUControl = 4'd0; bus.SrcA = 1; bus.SrcB = 1;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0; bus.Kill = 1'b0;
    check("idle_kill_valid", W'(bus.Valid), W'(0));
    check("idle_kill_result", bus.ALUResult, last_res);
    @(negedge clk);
    check("idle_kill_valid2", W'(bus.Valid), W'(0));

    // Asynchronous reset in the middle of a MUL
    bus.Start = 1'b1; bus.ALUControl = 4'd10; bus.SrcA = 3; bus.SrcB = 5;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    check("mul_busy_ready", W'(bus.Ready), W'(0));
    #2 rst = 1'b0;
    #1;
    check("async_rst_ready", W'(bus.Ready), W'(1));
    check("async_rst_valid", W'(bus.Valid), W'(0));
    check("async_rst_result", bus.ALUResult, '0);
    check("async_rst_zero", W'(bus.Zero), W'(1));
    check("async_rst_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(1, 40)));
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
